// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the RV32I 5-stage pipeline.
// It produces stall, flush and forwarding controls, sequences the boot
// bubbles after reset, tracks instruction-memory waits with a sticky
// timeout, and keeps saturating stall and flush counters.
module hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned MAX_WAIT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        imem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        imem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BOOT_W-1:0]   r_boot_cnt;
  logic [BOOT_W-1:0]   w_boot_cnt_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_nxt;
  logic                r_timeout;
  logic                w_timeout_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_lw_stall;

  assign imem_timeout = r_timeout;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  // State register together with the boot/wait counters and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state logic: boot sequencing, imem wait tracking and redirect exit.
  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    case (r_state)
      ST_BOOT: begin
        w_boot_cnt_nxt = r_boot_cnt + BOOT_W'(1);
        if (r_boot_cnt >= BOOT_W'(BOOT_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!PCSrcE && !imem_ready) begin
          w_state_nxt    = ST_IMEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
          if (MAX_WAIT <= 1) begin
            w_timeout_nxt = 1'b1;
          end
        end
      end
      ST_IMEM_WAIT: begin
        if (PCSrcE || imem_ready) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt < WAIT_W'(MAX_WAIT)) begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          if (r_wait_cnt >= WAIT_W'(MAX_WAIT - 1)) begin
            w_timeout_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Output logic: pipeline controls by priority, forwarding in every state.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;

    // RUN and IMEM_WAIT share one priority chain: a ready cycle in IMEM_WAIT
    // already behaves as RUN, and a not-ready one matches the RUN wait case.
    if (rst || (r_state == ST_BOOT) || (r_state == 2'd3)) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (!imem_ready || w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end

    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end

    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  // Saturating performance counters, frozen while booting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != ST_BOOT) begin
      if (StallF && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (FlushD && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with BOOT_CYCLES=2, MAX_WAIT=4.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, imem_ready;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        imem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.BOOT_CYCLES(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RdM(RdM), .RdW(RdW),
    .imem_ready(imem_ready),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .imem_timeout(imem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl();
    return {28'd0, StallF, StallD, FlushD, FlushE};
  endfunction

  initial begin
    rst = 1'b1;
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; imem_ready = 1'b1;

    // Reset and boot: controls {StallF,StallD,FlushD,FlushE}
    #2 check("rst_ctl", ctl(), 32'hF);
    cyc();
    check("rst_ctl_edge", ctl(), 32'hF);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_timeout", {31'd0, imem_timeout}, 32'd0);
    rst = 1'b0;
    #1 check("boot1_ctl", ctl(), 32'hF);
    cyc();
    check("boot2_ctl", ctl(), 32'hF);
    cyc();
    check("run_ctl", ctl(), 32'h0);
    check("run_stall_cnt", stall_cnt, 32'd0);
    check("run_flush_cnt", flush_cnt, 32'd0);

    // Load-use hazard
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1 check("lw_ctl", ctl(), 32'hD);
    cyc();
    check("lw_stall_cnt", stall_cnt, 32'd1);
    RdE = 5'd0; Rs1D = 5'd0;
    #1 check("lw_x0_ctl", ctl(), 32'h0);
    cyc();
    check("lw_x0_stall_cnt", stall_cnt, 32'd1);

    // Redirect beats load-use
    RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
    #1 check("br_ctl", ctl(), 32'h3);
    cyc();
    check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_stall_cnt", stall_cnt, 32'd1);
    PCSrcE = 1'b0; ResultSrcE0 = 1'b0; RdE = 5'd0; Rs1D = 5'd0;

    // Forwarding
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7;
    Rs1E = 5'd7; Rs2E = 5'd3;
    #1 check("fwd_a_mem", {30'd0, ForwardAE}, 32'd2);
    check("fwd_b_none", {30'd0, ForwardBE}, 32'd0);
    RdM = 5'd0;
    #1 check("fwd_a_wb", {30'd0, ForwardAE}, 32'd1);
    Rs2E = 5'd7; RdM = 5'd7; RegWriteM = 1'b0;
    #1 check("fwd_b_wb", {30'd0, ForwardBE}, 32'd1);
    RegWriteW = 1'b0;
    #1 check("fwd_a_off", {30'd0, ForwardAE}, 32'd0);
    Rs1E = 5'd0; Rs2E = 5'd0; RdM = 5'd0; RdW = 5'd0;

    // Short imem wait: three not-ready cycles, then ready with a load-use
    imem_ready = 1'b0;
    #1 check("wait1_ctl", ctl(), 32'hD);
    cyc();
    check("wait2_ctl", ctl(), 32'hD);
    cyc();
    cyc();
    check("wait3_timeout", {31'd0, imem_timeout}, 32'd0);
    imem_ready = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd9; Rs2D = 5'd9;
    #1 check("wait_exit_lw_ctl", ctl(), 32'hD);
    cyc();
    ResultSrcE0 = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    #1 check("wait_exit_ctl", ctl(), 32'h0);
    check("wait_exit_timeout", {31'd0, imem_timeout}, 32'd0);
    check("wait_stall_cnt", stall_cnt, 32'd5);
    check("wait_flush_cnt", flush_cnt, 32'd1);

    // Timeout after four consecutive not-ready cycles
    imem_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    check("to_pre", {31'd0, imem_timeout}, 32'd0);
    cyc();
    check("to_set", {31'd0, imem_timeout}, 32'd1);
    imem_ready = 1'b1;
    cyc();
    check("to_sticky", {31'd0, imem_timeout}, 32'd1);
    check("to_ctl", ctl(), 32'h0);
    imem_ready = 1'b0;
    cyc();
    cyc();
    check("pre_rst_stall_cnt", stall_cnt, 32'd11);

    // Reset mid-wait with a redirect pending
    PCSrcE = 1'b1; rst = 1'b1;
    #1 check("rst_wait_ctl", ctl(), 32'hF);
    cyc();
    check("rst_wait_stall_cnt", stall_cnt, 32'd0);
    check("rst_wait_flush_cnt", flush_cnt, 32'd0);
    check("rst_wait_timeout", {31'd0, imem_timeout}, 32'd0);
    rst = 1'b0;
    #1 check("reboot1_ctl", ctl(), 32'hF);
    cyc();
    check("reboot2_ctl", ctl(), 32'hF);
    check("reboot_stall_cnt", stall_cnt, 32'd0);
    cyc();
    check("rerun_br_ctl", ctl(), 32'h3);
    PCSrcE = 1'b0; imem_ready = 1'b1;
    #1 check("rerun_ctl", ctl(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
